// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU operation sequencer: op codes, FSM states,
// ALU control bundle and the op -> control decode table.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } alu_state_e;

   typedef struct packed {
      logic InvertA;
      logic InvertB;
      logic CarryIn;
      logic Or;
      logic FloodCarry;
   } alu_ctrl_t;

   // Control table for the downstream ALU. AND is built as NOR of the
   // inverted operands; compares reuse the subtract setup.
   function automatic alu_ctrl_t alu_ctrl_decode(alu_op_e op);
      alu_ctrl_t c;
      c = '0;
      case (op)
         ALU_SUB, ALU_SLT, ALU_SLTU: begin
            c.InvertB = 1'b1;
            c.CarryIn = 1'b1;
         end
         ALU_AND: begin
            c.InvertA    = 1'b1;
            c.InvertB    = 1'b1;
            c.Or         = 1'b1;
            c.FloodCarry = 1'b1;
         end
         ALU_OR:  c.Or         = 1'b1;
         ALU_XOR: c.FloodCarry = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic logic op_is_shift(alu_op_e op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

   // Codes above SRA are unassigned and complete with a zero result.
   function automatic logic op_is_legal(alu_op_e op);
      return (op <= ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Op request / result / ALU-side bundle between the sequencer and its
// environment. The sequencer uses the slave view; the surrounding
// execute stage (or a bench) uses the master view.
interface alu_sequencer_if #(
   parameter int Width = 32
);
   import alu_pkg::*;

   logic             OpValid;
   logic             OpReady;
   alu_op_e          OpCode;
   logic [Width-1:0] OpA;
   logic [Width-1:0] OpB;

   logic             ResValid;
   logic             ResReady;
   logic [Width-1:0] Result;

   logic [Width-1:0] AluInA;
   logic [Width-1:0] AluInB;
   logic             AluCarryIn;
   logic             AluOr;
   logic             AluFloodCarry;
   logic             AluInvertA;
   logic             AluInvertB;
   logic             AluCarryOut;
   logic [Width-1:0] AluOutC;

   modport slave (
      input  OpValid, OpCode, OpA, OpB, ResReady, AluCarryOut, AluOutC,
      output OpReady, ResValid, Result,
      output AluInA, AluInB, AluCarryIn, AluOr, AluFloodCarry,
      output AluInvertA, AluInvertB
   );

   modport master (
      output OpValid, OpCode, OpA, OpB, ResReady, AluCarryOut, AluOutC,
      input  OpReady, ResValid, Result,
      input  AluInA, AluInB, AluCarryIn, AluOr, AluFloodCarry,
      input  AluInvertA, AluInvertB
   );

endinterface

// File: rtl/alu_sequencer.sv
// RV32 integer op sequencer in front of the ALU. One op per handshake;
// arithmetic/logic ops take a single EXEC cycle through the ALU, shifts
// iterate one bit per cycle, and the registered result is returned over
// a valid/ready handshake.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int Width = 32
) (
   input  logic           Clock,
   input  logic           Reset,
   alu_sequencer_if.slave bus
);

   localparam int SW  = $clog2(Width);
   localparam int MSB = Width - 1;
   localparam logic [SW-1:0] CntOne = SW'(1);

   alu_state_e       state_q, state_d;
   alu_op_e          op_q, op_d;
   logic [Width-1:0] a_q, a_d;
   logic [Width-1:0] b_q, b_d;
   logic [Width-1:0] acc_q, acc_d;
   logic [SW-1:0]    cnt_q, cnt_d;
   logic [Width-1:0] result_q, result_d;

   logic             op_ready;
   logic             res_valid;
   logic             accept;
   alu_ctrl_t        ctrl;
   logic [Width-1:0] in_a, in_b;
   logic [Width-1:0] exec_res;

   assign accept = bus.OpValid && op_ready;

   // State register.
   always_ff @(posedge Clock) begin
      if (Reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Datapath registers; reset discards any in-flight op.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         op_q     <= ALU_ADD;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   // Next-state selection.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (!op_is_legal(bus.OpCode))     state_d = ST_DONE;
               else if (op_is_shift(bus.OpCode)) state_d = ST_SHIFT;
               else                              state_d = ST_EXEC;
            end
         end
         ST_EXEC:  state_d = ST_DONE;
         ST_SHIFT: if (cnt_q == '0) state_d = ST_DONE;
         ST_DONE:  if (bus.ResReady) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Single-cycle result: compares are derived from the subtract.
   always_comb begin
      exec_res = bus.AluOutC;
      if (op_q == ALU_SLT) begin
         exec_res    = '0;
         // Differing signs decide directly; otherwise the difference sign does.
         exec_res[0] = (a_q[MSB] != b_q[MSB]) ? a_q[MSB] : bus.AluOutC[MSB];
      end else if (op_q == ALU_SLTU) begin
         exec_res    = '0;
         exec_res[0] = ~bus.AluCarryOut;
      end
   end

   // Operand latch, shift iteration and result capture.
   always_comb begin
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d = bus.OpCode;
               a_d  = bus.OpA;
               b_d  = bus.OpB;
               if (!op_is_legal(bus.OpCode)) begin
                  result_d = '0;
               end else if (op_is_shift(bus.OpCode)) begin
                  acc_d = bus.OpA;
                  cnt_d = bus.OpB[SW-1:0];
               end
            end
         end
         ST_EXEC: result_d = exec_res;
         ST_SHIFT: begin
            if (cnt_q == '0) begin
               result_d = acc_q;
            end else begin
               cnt_d = cnt_q - CntOne;
               case (op_q)
                  ALU_SLL: acc_d = bus.AluOutC;
                  ALU_SRL: acc_d = {1'b0, acc_q[MSB:1]};
                  ALU_SRA: acc_d = {acc_q[MSB], acc_q[MSB:1]};
                  default: acc_d = acc_q;
               endcase
            end
         end
         default: ;
      endcase
   end

   // Handshake and ALU drive; everything idles at zero, including during reset.
   always_comb begin
      op_ready  = 1'b0;
      res_valid = 1'b0;
      ctrl      = '0;
      in_a      = '0;
      in_b      = '0;
      if (!Reset) begin
         case (state_q)
            ST_IDLE: op_ready = 1'b1;
            ST_EXEC: begin
               ctrl = alu_ctrl_decode(op_q);
               in_a = a_q;
               in_b = b_q;
            end
            ST_SHIFT: begin
               // Left shift by one is acc + acc through the ALU adder.
               if (op_q == ALU_SLL && cnt_q != '0) begin
                  ctrl = alu_ctrl_decode(ALU_ADD);
                  in_a = acc_q;
                  in_b = acc_q;
               end
            end
            ST_DONE: res_valid = 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.OpReady       = op_ready;
   assign bus.ResValid      = res_valid;
   assign bus.Result        = result_q;
   assign bus.AluInA        = in_a;
   assign bus.AluInB        = in_b;
   assign bus.AluInvertA    = ctrl.InvertA;
   assign bus.AluInvertB    = ctrl.InvertB;
   assign bus.AluCarryIn    = ctrl.CarryIn;
   assign bus.AluOr         = ctrl.Or;
   assign bus.AluFloodCarry = ctrl.FloodCarry;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural stand-in for the ALU.
module tb_alu_sequencer;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   typedef struct {
      logic [31:0] res;
      int          due;
      string       tag;
   } exp_t;
   exp_t sb[$];

   alu_sequencer_if #(.Width(32)) bus ();

   alu_sequencer #(.Width(32)) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   // Behavioural ALU: invert stage, then add / or / xor, NOR when both set.
   function automatic logic [32:0] alu_model(input logic [31:0] a, b,
                                             input logic ia, ib, ci, orr, fl);
      logic [31:0] x, y;
      x = ia ? ~a : a;
      y = ib ? ~b : b;
      if (orr && fl) return {1'b0, ~(x | y)};
      if (orr)       return {1'b0, x | y};
      if (fl)        return {1'b0, x ^ y};
      return {1'b0, x} + {1'b0, y} + {32'd0, ci};
   endfunction

   assign {bus.AluCarryOut, bus.AluOutC} = alu_model(bus.AluInA, bus.AluInB,
      bus.AluInvertA, bus.AluInvertB, bus.AluCarryIn, bus.AluOr, bus.AluFloodCarry);

   function automatic logic [31:0] golden(input alu_op_e op, input logic [31:0] a, b);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: return {31'd0, a < b};
         ALU_SLL:  return a << sh;
         ALU_SRL:  return a >> sh;
         ALU_SRA:  return $signed(a) >>> sh;
         default:  return 32'd0;
      endcase
   endfunction

   function automatic int latency(input alu_op_e op, input logic [31:0] b);
      if (op > ALU_SRA) return 1;
      if (op == ALU_SLL || op == ALU_SRL || op == ALU_SRA) return 2 + int'(b[4:0]);
      return 2;
   endfunction

   // {InvertA, InvertB, CarryIn, Or, FloodCarry}
   function automatic logic [4:0] exp_ctrl(input alu_op_e op);
      case (op)
         ALU_SUB, ALU_SLT, ALU_SLTU: return 5'b01100;
         ALU_AND: return 5'b11011;
         ALU_OR:  return 5'b00010;
         ALU_XOR: return 5'b00001;
         default: return 5'b00000;
      endcase
   endfunction

   function automatic logic [31:0] ctrl_now();
      return {27'd0, bus.AluInvertA, bus.AluInvertB, bus.AluCarryIn,
              bus.AluOr, bus.AluFloodCarry};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   // Result monitor: latency, value, and stability while stalled.
   logic rv_prev = 1'b0;
   int   first_seen = 0;
   always @(negedge clk) begin
      exp_t e;
      int   fs;
      if (rst) begin
         rv_prev <= 1'b0;
      end else if (bus.ResValid) begin
         fs = rv_prev ? first_seen : cyc + 1;
         first_seen <= fs;
         rv_prev    <= 1'b1;
         if (sb.size() == 0) begin
            chk("sb_nonempty", 32'(sb.size()), 32'd1);
         end else if (bus.ResReady) begin
            e = sb.pop_front();
            chk({e.tag, "_res"}, bus.Result, e.res);
            chk({e.tag, "_lat"}, 32'(fs), 32'(e.due));
            rv_prev <= 1'b0;
         end else begin
            chk("stall_res", bus.Result, sb[0].res);
            chk("stall_opready", 32'(bus.OpReady), 32'd0);
         end
      end else begin
         rv_prev <= 1'b0;
      end
   end

   task automatic send(input string tag, input alu_op_e op, input logic [31:0] a, b);
      int   guard;
      int   t;
      exp_t e;
      guard = 0;
      @(posedge clk); #1;
      bus.OpValid = 1'b1;
      bus.OpCode  = op;
      bus.OpA     = a;
      bus.OpB     = b;
      @(negedge clk);
      while (!bus.OpReady && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.OpReady) begin
         chk({tag, "_opready_to"}, 32'(bus.OpReady), 32'd1);
         bus.OpValid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      t = cyc;
      bus.OpValid = 1'b0;
      e.res = golden(op, a, b);
      e.due = t + latency(op, b);
      e.tag = tag;
      sb.push_back(e);
      @(negedge clk);
      if (op <= ALU_XOR || op == ALU_SLT || op == ALU_SLTU) begin
         chk({tag, "_ina"}, bus.AluInA, a);
         chk({tag, "_inb"}, bus.AluInB, b);
         chk({tag, "_ctrl"}, ctrl_now(), {27'd0, exp_ctrl(op)});
      end else if (op == ALU_SLL && b[4:0] != 5'd0) begin
         chk({tag, "_sll_ina"}, bus.AluInA, a);
         chk({tag, "_sll_ctrl"}, ctrl_now(), 32'd0);
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      bus.OpValid  = 1'b0;
      bus.OpCode   = ALU_ADD;
      bus.OpA      = '0;
      bus.OpB      = '0;
      bus.ResReady = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_opready", 32'(bus.OpReady), 32'd0);
      chk("rst_resvalid", 32'(bus.ResValid), 32'd0);
      chk("rst_result", bus.Result, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_opready", 32'(bus.OpReady), 32'd1);

      send("sub", ALU_SUB, 32'd5, 32'd7);
      send("slt", ALU_SLT, 32'hFFFFFFFF, 32'd1);
      send("sltu", ALU_SLTU, 32'hFFFFFFFF, 32'd1);
      send("sltu_eq", ALU_SLTU, 32'h80000000, 32'h80000000);
      send("slt_pos", ALU_SLT, 32'd3, 32'h7FFFFFFF);
      send("and", ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00);
      send("or", ALU_OR, 32'hF0F0F0F0, 32'hFF00FF00);
      send("xor", ALU_XOR, 32'hF0F0F0F0, 32'hFF00FF00);
      send("add_wrap", ALU_ADD, 32'hFFFFFFFF, 32'd2);
      send("sra4", ALU_SRA, 32'h80000000, 32'hFFFFFFE4);
      send("sll31", ALU_SLL, 32'd1, 32'd31);
      send("srl0", ALU_SRL, 32'h12345678, 32'd0);
      send("srl7", ALU_SRL, 32'h80000001, 32'h00000107);
      for (int i = 0; i < 6; i++)
         send("rand", alu_op_e'(4'($urandom_range(0, 9))), $urandom, $urandom);
      send("illegal", alu_op_e'(4'd12), 32'hDEADBEEF, 32'd1);
      drain();

      // Backpressure: hold the result for 10 cycles
      bus.ResReady = 1'b0;
      send("stall_add", ALU_ADD, 32'h11111111, 32'h22222222);
      repeat (10) @(posedge clk);
      #1 bus.ResReady = 1'b1;
      drain();

      // Reset in the middle of a long left shift
      send("sll20", ALU_SLL, 32'h3, 32'd20);
      @(posedge clk); #1;
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("mid_rst_opready", 32'(bus.OpReady), 32'd0);
      chk("mid_rst_resvalid", 32'(bus.ResValid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("after_rst_result", bus.Result, 32'd0);
      chk("after_rst_ina", bus.AluInA, 32'd0);
      chk("after_rst_inb", bus.AluInB, 32'd0);
      chk("after_rst_ctrl", ctrl_now(), 32'd0);
      chk("after_rst_resvalid", 32'(bus.ResValid), 32'd0);
      chk("after_rst_opready", 32'(bus.OpReady), 32'd1);
      repeat (30) @(posedge clk);
      send("add_2_3", ALU_ADD, 32'd2, 32'd3);
      drain();

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
